// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, the four control tokens (also used by the
// transmit encoder) and the receive alignment state encoding.
package tmds_pkg;

    localparam int TMDS_W = 10;

    // Control tokens as they appear in bits 9..0 of an aligned symbol.
    localparam logic [TMDS_W-1:0] CTRL_TOK0 = 10'b1101010100;  // cd = 00
    localparam logic [TMDS_W-1:0] CTRL_TOK1 = 10'b0010101011;  // cd = 01
    localparam logic [TMDS_W-1:0] CTRL_TOK2 = 10'b0101010100;  // cd = 10
    localparam logic [TMDS_W-1:0] CTRL_TOK3 = 10'b1010101011;  // cd = 11

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    // Bit offsets run 0..9 and wrap.
    function automatic logic [3:0] slip_next(input logic [3:0] s);
        return (s == 4'd9) ? 4'd0 : s + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_decoder_align_if.sv
// Word-in / decoded-symbol-out bundle between the deserializer, the channel decoder
// and the capture logic.
interface tmds_decoder_align_if;
    import tmds_pkg::*;

    logic [TMDS_W-1:0] in_word;
    logic [7:0]        vd;
    logic [1:0]        cd;
    logic              vde;
    logic              locked;
    logic [3:0]        slip;

    modport master (
        output in_word,
        input  vd, cd, vde, locked, slip
    );

    modport slave (
        input  in_word,
        output vd, cd, vde, locked, slip
    );

endinterface

// File: rtl/tmds_symbol_decode.sv
// Aligned 10-bit TMDS symbol -> {is_ctrl, cd, vd}; purely combinational, zero latency,
// no backpressure.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [TMDS_W-1:0] sym,
    output logic              is_ctrl,
    output logic [1:0]        cd,
    output logic [7:0]        vd
);

    logic [7:0] q;

    always_comb begin
        is_ctrl = 1'b1;
        cd      = 2'b00;
        case (sym)
            CTRL_TOK0: cd = 2'b00;
            CTRL_TOK1: cd = 2'b01;
            CTRL_TOK2: cd = 2'b10;
            CTRL_TOK3: cd = 2'b11;
            default:   is_ctrl = 1'b0;
        endcase
    end

    // Undo the DC-balance inversion, then the XOR/XNOR transition chain.
    always_comb begin
        q     = sym[9] ? ~sym[7:0] : sym[7:0];
        vd    = 8'h00;
        vd[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            vd[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder_align.sv
// TMDS receive channel: finds symbol alignment from control-token runs, slips 0..9 bits,
// decodes to vd/cd/vde; fixed 2-cycle latency, free-running with no backpressure.
module tmds_decoder_align
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN   = 8,
    parameter int SEARCH_WIN = 1024,
    parameter int LOSS_WIN   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tmds_decoder_align_if.slave  tmds
);

    localparam int WIN_W  = $clog2(SEARCH_WIN);
    localparam int RUN_W  = $clog2(CTRL_RUN);
    localparam int LOSS_W = $clog2(LOSS_WIN);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
    // Compared before increment, so lock drops on the (LOSS_WIN-1)-th non-token.
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WIN - 2);

    logic [TMDS_W-1:0]   prev_q;
    logic [TMDS_W-1:0]   aligned_q;
    logic [2*TMDS_W-1:0] cat;

    align_state_t        state_q, state_d;
    logic [3:0]          slip_q, slip_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic                settle_q, settle_d;

    logic [7:0]          vd_q, vd_d;
    logic [1:0]          cd_q, cd_d;
    logic                vde_q, vde_d;

    logic                is_ctrl;
    logic [1:0]          dec_cd;
    logic [7:0]          dec_vd;
    logic                lock_d;

    // Newer word on top: the window starting at bit 'slip' of the older word.
    assign cat = {tmds.in_word, prev_q};

    tmds_symbol_decode u_decode (
        .sym     (aligned_q),
        .is_ctrl (is_ctrl),
        .cd      (dec_cd),
        .vd      (dec_vd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q    <= '0;
            aligned_q <= '0;
        end else begin
            prev_q    <= tmds.in_word;
            aligned_q <= cat[slip_q +: TMDS_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        slip_d   = slip_q;
        win_d    = win_q;
        run_d    = run_q;
        loss_d   = loss_q;
        settle_d = settle_q;

        unique case (state_q)
            SEARCH: begin
                win_d = win_q + 1'b1;
                run_d = is_ctrl ? run_q + 1'b1 : '0;
                if (is_ctrl && (run_q == RUN_LAST)) begin
                    state_d = LOCKED;
                    win_d   = '0;
                    run_d   = '0;
                    loss_d  = '0;
                end else if (win_q == WIN_LAST) begin
                    state_d  = SETTLE;
                    slip_d   = slip_next(slip_q);
                    win_d    = '0;
                    run_d    = '0;
                    settle_d = 1'b0;
                end
            end
            // Two idle cycles so the word aligned under the old slip is not counted.
            SETTLE: begin
                settle_d = 1'b1;
                if (settle_q) begin
                    state_d  = SEARCH;
                    settle_d = 1'b0;
                end
            end
            LOCKED: begin
                loss_d = is_ctrl ? '0 : loss_q + 1'b1;
                if (!is_ctrl && (loss_q == LOSS_LAST)) begin
                    state_d = SEARCH;
                    win_d   = '0;
                    run_d   = '0;
                    loss_d  = '0;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Outputs follow the next lock state so they blank on the same edge lock drops.
    always_comb begin
        lock_d = (state_d == LOCKED);
        vde_d  = 1'b0;
        vd_d   = 8'h00;
        cd_d   = 2'b00;
        if (lock_d) begin
            if (is_ctrl) begin
                cd_d = dec_cd;
            end else begin
                vde_d = 1'b1;
                vd_d  = dec_vd;
                cd_d  = cd_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            slip_q   <= '0;
            win_q    <= '0;
            run_q    <= '0;
            loss_q   <= '0;
            settle_q <= 1'b0;
            vd_q     <= '0;
            cd_q     <= '0;
            vde_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slip_q   <= slip_d;
            win_q    <= win_d;
            run_q    <= run_d;
            loss_q   <= loss_d;
            settle_q <= settle_d;
            vd_q     <= vd_d;
            cd_q     <= cd_d;
            vde_q    <= vde_d;
        end
    end

    assign tmds.vd     = vd_q;
    assign tmds.cd     = cd_q;
    assign tmds.vde    = vde_q;
    assign tmds.locked = (state_q == LOCKED);
    assign tmds.slip   = slip_q;

endmodule
